// File: rtl/dram_bank_scheduler_if.sv
// Request / command bundle between the L2 request decoder, the bank
// scheduler and the DRAM command port.
//
// Port summary (signal: driver):
//   req_valid, req_rw, req_bank, req_row, req_col : request source
//   req_ready                                     : scheduler
//   refresh_flag                                  : refresh counter
//   refresh_done                                  : scheduler
//   cmd_req, cmd, cmd_bank, cmd_row, cmd_col      : scheduler
//   cmd_ack                                       : DRAM command port
//   rw_done                                       : scheduler
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready.
// A command transfers on a rising edge where cmd_req && cmd_ack. Once raised,
// cmd_req and its fields stay stable until that transfer. cmd_ack seen while
// cmd_req is low is ignored.
//
// Modports: master = environment side (request source, refresh counter and
// DRAM port); slave = scheduler side.
interface dram_bank_scheduler_if #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
);
  localparam int BW = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int RW = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1;
  localparam int CW = (NUM_OF_COLS  > 1) ? $clog2(NUM_OF_COLS)  : 1;

  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [BW-1:0] req_bank;
  logic [RW-1:0] req_row;
  logic [CW-1:0] req_col;
  logic          refresh_flag;
  logic          refresh_done;
  logic          cmd_req;
  logic          cmd_ack;
  logic [2:0]    cmd;
  logic [BW-1:0] cmd_bank;
  logic [RW-1:0] cmd_row;
  logic [CW-1:0] cmd_col;
  logic          rw_done;

  modport master (
    output req_valid, req_rw, req_bank, req_row, req_col, refresh_flag, cmd_ack,
    input  req_ready, refresh_done, cmd_req, cmd, cmd_bank, cmd_row, cmd_col, rw_done
  );

  modport slave (
    input  req_valid, req_rw, req_bank, req_row, req_col, refresh_flag, cmd_ack,
    output req_ready, refresh_done, cmd_req, cmd, cmd_bank, cmd_row, cmd_col, rw_done
  );
endinterface

// File: rtl/dram_bank_scheduler.sv
// DRAM bank scheduler: turns decoded L2 requests into PRE/ACT/RD/WR command
// sequences. It tracks the open row of every bank and enforces tRP/tRCD spacing.
// Refresh requests take priority over new L2 traffic and run PREA (only if a
// bank is open), then REF, then a tRFC wait.
//
// Ports:
//   clk          : clock, rising edge
//   rst_b        : asynchronous active-low reset
//   bus          : dram_bank_scheduler_if.slave (request, refresh and command signals)
//   dbg_state_o  : current FSM state, for checkers and debug
//
// Command encoding: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF.
module dram_bank_scheduler #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RP         = 3,
  parameter int T_RCD        = 3,
  parameter int T_RFC        = 8
) (
  input  logic                        clk,
  input  logic                        rst_b,
  dram_bank_scheduler_if.slave        bus,
  output logic [3:0]                  dbg_state_o
);
  localparam int BW = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int RW = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1;
  localparam int CW = (NUM_OF_COLS  > 1) ? $clog2(NUM_OF_COLS)  : 1;

  localparam int T_MAX1 = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int T_MAX  = (T_MAX1 > T_RFC) ? T_MAX1 : T_RFC;
  localparam int TW     = $clog2(T_MAX) + 1;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    PRE_S    = 4'd1,
    PREA_S   = 4'd2,
    ACT_S    = 4'd3,
    RW_S     = 4'd4,
    REF_S    = 4'd5,
    WAIT_RP  = 4'd6,
    WAIT_RCD = 4'd7,
    WAIT_RFC = 4'd8
  } state_t;

  state_t                             state_q, state_d;
  logic                               ref_pending_q, ref_pending_d;
  logic [NUM_OF_BANKS-1:0]            open_q, open_d;
  logic [NUM_OF_BANKS-1:0][RW-1:0]    row_tab_q, row_tab_d;
  logic [TW-1:0]                      timer_q, timer_d;
  logic                               rw_q, rw_d;
  logic [BW-1:0]                      bank_q, bank_d;
  logic [RW-1:0]                      row_q, row_d;
  logic [CW-1:0]                      col_q, col_d;
  // Set when the current tRP wait follows a PREA, so it leads to REF rather than ACT.
  logic                               rp_to_ref_q, rp_to_ref_d;
  logic                               rw_done_q, rw_done_d;
  logic                               refresh_done_q, refresh_done_d;

  logic                               req_ready;
  logic                               accept;
  logic                               cmd_req_c;
  logic [2:0]                         cmd_c;

  assign req_ready = (state_q == IDLE) && !ref_pending_q;
  assign accept    = bus.req_valid && req_ready;

  // Command outputs are decoded from the registered state, so cmd_req/cmd drop
  // to 0/NOP on the same edge that consumes the ack.
  always_comb begin
    cmd_req_c = 1'b0;
    cmd_c     = CMD_NOP;
    case (state_q)
      PRE_S:   begin cmd_req_c = 1'b1; cmd_c = CMD_PRE;  end
      PREA_S:  begin cmd_req_c = 1'b1; cmd_c = CMD_PREA; end
      ACT_S:   begin cmd_req_c = 1'b1; cmd_c = CMD_ACT;  end
      RW_S:    begin cmd_req_c = 1'b1; cmd_c = rw_q ? CMD_WR : CMD_RD; end
      REF_S:   begin cmd_req_c = 1'b1; cmd_c = CMD_REF;  end
      default: begin cmd_req_c = 1'b0; cmd_c = CMD_NOP;  end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    ref_pending_d  = ref_pending_q;
    open_d         = open_q;
    row_tab_d      = row_tab_q;
    timer_d        = timer_q;
    rw_d           = rw_q;
    bank_d         = bank_q;
    row_d          = row_q;
    col_d          = col_q;
    rp_to_ref_d    = rp_to_ref_q;
    rw_done_d      = 1'b0;
    refresh_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ref_pending_q) begin
          // A PREA is only needed if a bank is open.
          state_d = (|open_q) ? PREA_S : REF_S;
        end else if (accept) begin
          rw_d   = bus.req_rw;
          bank_d = bus.req_bank;
          row_d  = bus.req_row;
          col_d  = bus.req_col;
          if (open_q[bus.req_bank]) begin
            state_d = (row_tab_q[bus.req_bank] == bus.req_row) ? RW_S : PRE_S;
          end else begin
            state_d = ACT_S;
          end
        end
      end
      PRE_S: begin
        if (bus.cmd_ack) begin
          open_d[bank_q] = 1'b0;
          timer_d        = TW'(T_RP - 1);
          rp_to_ref_d    = 1'b0;
          state_d        = WAIT_RP;
        end
      end
      PREA_S: begin
        if (bus.cmd_ack) begin
          open_d      = '0;
          timer_d     = TW'(T_RP - 1);
          rp_to_ref_d = 1'b1;
          state_d     = WAIT_RP;
        end
      end
      ACT_S: begin
        if (bus.cmd_ack) begin
          open_d[bank_q]    = 1'b1;
          row_tab_d[bank_q] = row_q;
          timer_d           = TW'(T_RCD - 1);
          state_d           = WAIT_RCD;
        end
      end
      RW_S: begin
        if (bus.cmd_ack) begin
          rw_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      REF_S: begin
        if (bus.cmd_ack) begin
          ref_pending_d = 1'b0;
          open_d        = '0;
          timer_d       = TW'(T_RFC - 1);
          state_d       = WAIT_RFC;
        end
      end
      WAIT_RP: begin
        if (timer_q == '0) state_d = rp_to_ref_q ? REF_S : ACT_S;
        else               timer_d = timer_q - TW'(1);
      end
      WAIT_RCD: begin
        if (timer_q == '0) state_d = RW_S;
        else               timer_d = timer_q - TW'(1);
      end
      WAIT_RFC: begin
        if (timer_q == '0) begin
          state_d        = IDLE;
          refresh_done_d = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A new refresh request on the same edge as the REF ack must not be lost.
    if (bus.refresh_flag) ref_pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= IDLE;
      ref_pending_q  <= 1'b0;
      open_q         <= '0;
      row_tab_q      <= '0;
      timer_q        <= '0;
      rw_q           <= 1'b0;
      bank_q         <= '0;
      row_q          <= '0;
      col_q          <= '0;
      rp_to_ref_q    <= 1'b0;
      rw_done_q      <= 1'b0;
      refresh_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_pending_q  <= ref_pending_d;
      open_q         <= open_d;
      row_tab_q      <= row_tab_d;
      timer_q        <= timer_d;
      rw_q           <= rw_d;
      bank_q         <= bank_d;
      row_q          <= row_d;
      col_q          <= col_d;
      rp_to_ref_q    <= rp_to_ref_d;
      rw_done_q      <= rw_done_d;
      refresh_done_q <= refresh_done_d;
    end
  end

  // Field outputs show the latched request; only cmd_req/cmd say when they mean something.
  assign bus.req_ready    = req_ready;
  assign bus.cmd_req      = cmd_req_c;
  assign bus.cmd          = cmd_c;
  assign bus.cmd_bank     = bank_q;
  assign bus.cmd_row      = row_q;
  assign bus.cmd_col      = col_q;
  assign bus.rw_done      = rw_done_q;
  assign bus.refresh_done = refresh_done_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_dram_bank_scheduler.sv
module tb_dram_bank_scheduler;
  localparam int NB = 8, NR = 128, NC = 8;
  localparam int T_RP = 3, T_RCD = 3, T_RFC = 8;
  localparam int BW = 3, RW = 7, CW = 3;
  localparam int EW = 8 + 3 + BW + RW + CW;

  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dram_bank_scheduler_if #(.NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus();
  logic [3:0] dbg_state;

  dram_bank_scheduler #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
    .T_RP(T_RP), .T_RCD(T_RCD), .T_RFC(T_RFC)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .bus(bus.slave),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  // Entry layout: {gap[7:0], cmd[2:0], bank, row, col}. gap = cycles from the last
  // accept/ack to this command's cmd_req rising; 0 means "not checked".
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int ref_outstanding = 0;
  int ack_mode = 0;  // 0: ack every cycle, 1: random ack, 2: hold ack low
  bit m_open[NB];
  int m_row[NB];

  task automatic check(input bit ok, input string name, input longint act, input longint expv);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void push_exp(input logic [2:0] c, input int b, input int r, input int col, input int gap);
    logic [EW-1:0] e;
    e = {8'(gap), c, BW'(b), RW'(r), CW'(col)};
    exp_q.push_back(e);
  endfunction

  // Reference model: what command sequence a request needs, given the open-row table.
  function automatic void model_req(input bit rw, input int b, input int r, input int col);
    logic [2:0] rwc;
    rwc = rw ? C_WR : C_RD;
    if (m_open[b] && m_row[b] == r) begin
      push_exp(rwc, b, r, col, 1);
    end else begin
      if (m_open[b]) begin
        push_exp(C_PRE, b, 0, 0, 1);
        push_exp(C_ACT, b, r, 0, T_RP + 1);
      end else begin
        push_exp(C_ACT, b, r, 0, 1);
      end
      push_exp(rwc, b, r, col, T_RCD + 1);
    end
    m_open[b] = 1'b1;
    m_row[b]  = r;
  endfunction

  function automatic void model_refresh();
    bit any_open;
    any_open = 1'b0;
    for (int i = 0; i < NB; i++) any_open |= m_open[i];
    if (any_open) begin
      push_exp(C_PREA, 0, 0, 0, 0);
      push_exp(C_REF, 0, 0, 0, T_RP + 1);
    end else begin
      push_exp(C_REF, 0, 0, 0, 0);
    end
    for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
    ref_outstanding++;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
    end
  endfunction

  // ---------------- DRAM-side ack driver ----------------
  initial begin
    bus.cmd_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       bus.cmd_ack = 1'b1;
        1:       bus.cmd_ack = 1'($urandom_range(0, 1));
        default: bus.cmd_ack = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  int last_evt = -100, rw_ack_cyc = -100, ref_ack_cyc = -100, rdone_cyc = -100;
  bit prev_req = 1'b0;
  logic [2:0] prev_cmd;
  logic [BW-1:0] prev_bank;
  logic [RW-1:0] prev_row;
  logic [CW-1:0] prev_col;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [2:0] ec;
    int gap;
    bit exp_p;
    if (!rst_b) begin
      prev_req    = 1'b0;
      last_evt    = -100;
      rw_ack_cyc  = -100;
      ref_ack_cyc = -100;
    end else begin
      exp_p = (cyc == rw_ack_cyc + 1);
      if (exp_p || bus.rw_done) check(bus.rw_done == exp_p, "rw_done", bus.rw_done, exp_p);
      exp_p = (cyc == ref_ack_cyc + T_RFC + 1);
      if (exp_p || bus.refresh_done) check(bus.refresh_done == exp_p, "refresh_done", bus.refresh_done, exp_p);
      if (bus.refresh_done) rdone_cyc = cyc;
      if (bus.req_valid && bus.req_ready) last_evt = cyc;

      if (bus.cmd_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_cmd", bus.cmd, C_NOP);
        end else begin
          e   = exp_q[0];
          gap = int'(e[EW-1 -: 8]);
          if (gap != 0) check(cyc - last_evt == gap, "cmd_gap", cyc - last_evt, gap);
        end
      end

      if (bus.cmd_req && prev_req)
        check({bus.cmd, bus.cmd_bank, bus.cmd_row, bus.cmd_col} == {prev_cmd, prev_bank, prev_row, prev_col},
              "hold_stable", {bus.cmd, bus.cmd_bank, bus.cmd_row, bus.cmd_col},
              {prev_cmd, prev_bank, prev_row, prev_col});

      if (bus.cmd_req && bus.cmd_ack) begin
        if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          ec = e[EW-9 -: 3];
          check(bus.cmd == ec, "cmd_type", bus.cmd, ec);
          if (ec == C_ACT || ec == C_RD || ec == C_WR || ec == C_PRE)
            check(bus.cmd_bank == e[CW+RW +: BW], "cmd_bank", bus.cmd_bank, e[CW+RW +: BW]);
          if (ec == C_ACT)
            check(bus.cmd_row == e[CW +: RW], "cmd_row", bus.cmd_row, e[CW +: RW]);
          if (ec == C_RD || ec == C_WR)
            check(bus.cmd_col == e[CW-1:0], "cmd_col", bus.cmd_col, e[CW-1:0]);
          if (ec == C_REF) ref_outstanding--;
        end
        last_evt = cyc;
        if (bus.cmd == C_RD || bus.cmd == C_WR) rw_ack_cyc = cyc;
        if (bus.cmd == C_REF) ref_ack_cyc = cyc;
      end

      prev_req  = bus.cmd_req && !bus.cmd_ack;
      prev_cmd  = bus.cmd;
      prev_bank = bus.cmd_bank;
      prev_row  = bus.cmd_row;
      prev_col  = bus.cmd_col;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input bit rw, input int b, input int r, input int col);
    bus.req_rw    = rw;
    bus.req_bank  = BW'(b);
    bus.req_row   = RW'(r);
    bus.req_col   = CW'(col);
    bus.req_valid = 1'b1;
  endtask

  task automatic wait_accept(input bit rw, input int b, input int r, input int col, output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    if (!got) check(1'b0, "accept_timeout", 0, 1);
    else model_req(rw, b, r, col);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic send_req(input bit rw, input int b, input int r, input int col);
    int acc;
    @(posedge clk);
    #1 drive_req(rw, b, r, col);
    wait_accept(rw, b, r, col, acc);
  endtask

  task automatic do_refresh();
    for (int i = 0; i < 500 && ref_outstanding != 0; i++) @(posedge clk);
    @(posedge clk);
    #1 bus.refresh_flag = 1'b1;
    model_refresh();
    @(posedge clk);
    #1 bus.refresh_flag = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (T_RFC + 4) @(negedge clk);
    check(exp_q.size() == 0, name, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    rst_b            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_rw       = 1'b0;
    bus.req_bank     = '0;
    bus.req_row      = '0;
    bus.req_col      = '0;
    bus.refresh_flag = 1'b0;
    ack_mode         = 1;
    model_clear();

    // 1: reset values, then 20 idle cycles with stray acks
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({bus.cmd_req, bus.cmd, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.rw_done, bus.refresh_done} == '0,
          "reset_outputs", {bus.cmd_req, bus.cmd, bus.cmd_bank, bus.cmd_row, bus.cmd_col}, 0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check(bus.cmd_req == 1'b0 && bus.cmd == C_NOP && bus.req_ready == 1'b1,
            "idle_outputs", {bus.cmd_req, bus.cmd, bus.req_ready}, {1'b0, C_NOP, 1'b1});
    end

    // 2: closed bank read, ack in the same cycle
    ack_mode = 0;
    send_req(1'b0, 2, 5, 3);
    wait_drain("drain_closed_rd");

    // 3: row hit write
    send_req(1'b1, 2, 5, 7);
    wait_drain("drain_hit_wr");

    // 4: row miss, then a hit on the new row confirms the table
    send_req(1'b0, 2, 9, 0);
    wait_drain("drain_miss_rd");
    send_req(1'b0, 2, 9, 6);
    wait_drain("drain_new_row_hit");

    // 5: refresh and request together with bank 2 open
    @(posedge clk);
    #1 bus.refresh_flag = 1'b1;
    model_refresh();
    @(posedge clk);
    #1 drive_req(1'b0, 2, 9, 1);
    @(negedge clk);
    check(bus.req_ready == 1'b0, "ref_blocks_req", bus.req_ready, 0);
    @(posedge clk);
    #1 bus.refresh_flag = 1'b0;
    wait_accept(1'b0, 2, 9, 1, acc);
    check(acc == rdone_cyc, "accept_after_refresh", acc, rdone_cyc);
    wait_drain("drain_refresh");

    // 6: ACT held without ack, then reset mid-hold
    ack_mode = 2;
    send_req(1'b0, 5, 3, 4);
    repeat (10) @(negedge clk);
    check(bus.cmd_req == 1'b1 && bus.cmd == C_ACT && bus.cmd_bank == 3'd5 && bus.cmd_row == 7'd3,
          "act_held", {bus.cmd_req, bus.cmd, bus.cmd_bank, bus.cmd_row}, {1'b1, C_ACT, 3'd5, 7'd3});
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    check({bus.cmd_req, bus.cmd, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.rw_done, bus.refresh_done} == '0,
          "reset_mid_hold", {bus.cmd_req, bus.cmd, bus.cmd_bank, bus.cmd_row, bus.cmd_col}, 0);
    exp_q.delete();
    model_clear();
    ref_outstanding = 0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    ack_mode = 0;
    send_req(1'b0, 5, 3, 4);
    wait_drain("drain_after_reset");

    // random traffic with refreshes and random ack timing
    for (int i = 0; i < 40; i++) begin
      ack_mode = int'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) do_refresh();
      send_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, NC - 1)));
    end
    ack_mode = 1;
    do_refresh();
    wait_drain("drain_random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
